// File: rtl/wb_pkg.sv
// Shared Wishbone B3 types: cycle/burst type encodings, wb_spram FSM states,
// and the burst address sequencer used by the slave.
package wb_pkg;

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_INCR    = 3'b010,
    CTI_EOB     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACK   = 2'd1,
    BURST = 2'd2,
    ERR   = 2'd3
  } wb_spram_state_e;

  // Wrap bursts only advance the low bits; callers truncate to their address width.
  function automatic logic [31:0] wb_next_adr(input logic [31:0] adr, input bte_e bte);
    logic [31:0] n;
    n = adr;
    case (bte)
      BTE_WRAP4:  n[1:0] = adr[1:0] + 2'd1;
      BTE_WRAP8:  n[2:0] = adr[2:0] + 3'd1;
      BTE_WRAP16: n[3:0] = adr[3:0] + 4'd1;
      default:    n = adr + 32'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/spram_be.sv
// Byte-lane synchronous single-port RAM with registered read data.
// LANE_W is 8, or 9 when each byte carries a parity bit.
module spram_be #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 256,
  parameter int LANE_W    = 8,
  parameter int ADDR_W    = 8,
  parameter     INIT_FILE = ""
) (
  input  logic                            i_clk,
  input  logic                            i_clr,
  input  logic                            i_we,
  input  logic                            i_re,
  input  logic [DATA_W/8-1:0]             i_be,
  input  logic [ADDR_W-1:0]               i_addr,
  input  logic [(DATA_W/8)*LANE_W-1:0]    i_wdata,
  output logic [(DATA_W/8)*LANE_W-1:0]    o_q
);

  localparam int LANES = DATA_W / 8;
  localparam int MEM_W = LANES * LANE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [MEM_W-1:0] r_mem [DEPTH];
  logic [MEM_W-1:0] r_q_p1;
  logic             w_in_rng;

  assign w_in_rng = {1'b0, i_addr} < DEPTH_L;

  always_ff @(posedge i_clk) begin
    if (i_we && w_in_rng) begin
      for (int k = 0; k < LANES; k++) begin
        if (i_be[k]) r_mem[i_addr][k*LANE_W +: LANE_W] <= i_wdata[k*LANE_W +: LANE_W];
      end
    end
  end

  // Read port stage: q holds until the next read, cleared only by bus reset.
  always_ff @(posedge i_clk) begin
    if (i_clr)                  r_q_p1 <= '0;
    else if (i_re && w_in_rng)  r_q_p1 <= r_mem[i_addr];
  end

  assign o_q = r_q_p1;

endmodule

// File: rtl/wb_spram.sv
// Wishbone B3 slave around spram_be: classic, incrementing and wrap bursts,
// out-of-range error response. Define WB_SPRAM_PARITY_EN for per-byte parity.
module wb_spram
  import wb_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 8,
  parameter int DEPTH     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                cyc_i,
  input  logic                stb_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   adr_i,
  input  logic [DATA_W/8-1:0] sel_i,
  input  logic [DATA_W-1:0]   dat_i,
  input  logic [2:0]          cti_i,
  input  logic [1:0]          bte_i,
  output logic [DATA_W-1:0]   dat_o,
  output logic                ack_o,
  output logic                err_o
);

  localparam int BYTES = DATA_W / 8;
`ifdef WB_SPRAM_PARITY_EN
  localparam int LANE_W = 9;
`else
  localparam int LANE_W = 8;
`endif
  localparam int MEM_W = BYTES * LANE_W;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  wb_spram_state_e   r_state;
  logic [ADDR_W-1:0] r_ac;
  logic              r_ack;
  logic              r_err;

  logic [ADDR_W-1:0] w_next;
  logic [ADDR_W-1:0] w_ram_addr;
  logic              w_adr_ok;
  logic              w_next_ok;
  logic              w_acc;
  logic              w_ack;
  logic              w_hs;
  logic              w_burst_go;
  logic              w_wr;
  logic              w_rd;
  logic              w_perr;
  logic [MEM_W-1:0]  w_wdata;
  logic [MEM_W-1:0]  w_q;
  logic [DATA_W-1:0] w_rdata;

  assign w_next     = ADDR_W'(wb_next_adr(32'(r_ac), bte_e'(bte_i)));
  assign w_adr_ok   = {1'b0, adr_i} < DEPTH_L;
  assign w_next_ok  = {1'b0, w_next} < DEPTH_L;
  assign w_acc      = (r_state == IDLE) && cyc_i && stb_i;
  assign w_hs       = cyc_i && stb_i && w_ack;
  assign w_burst_go = (r_state == BURST) && w_hs && (cti_i == CTI_INCR);

  // Reset at an edge suppresses the write of the beat in flight.
  assign w_wr       = rst_n_i && w_hs && we_i;
  assign w_rd       = rst_n_i && !we_i && ((w_acc && w_adr_ok) || (w_burst_go && w_next_ok));
  assign w_ram_addr = (r_state == IDLE) ? adr_i : (w_wr ? r_ac : w_next);

`ifdef WB_SPRAM_PARITY_EN
  logic [BYTES-1:0] w_lane_perr;
  logic             r_vld_p1;

  always_comb begin
    w_wdata     = '0;
    w_rdata     = '0;
    w_lane_perr = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_wdata[k*LANE_W +: LANE_W] = {^dat_i[8*k +: 8], dat_i[8*k +: 8]};
      w_rdata[8*k +: 8]           = w_q[k*LANE_W +: 8];
      w_lane_perr[k]              = ^w_q[k*LANE_W +: LANE_W];
    end
  end

  // Parity is only meaningful on a beat whose data was just read.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) r_vld_p1 <= 1'b0;
    else          r_vld_p1 <= w_rd;
  end

  assign w_perr = r_vld_p1 && (|w_lane_perr);
`else
  always_comb begin
    w_wdata = '0;
    w_rdata = '0;
    for (int k = 0; k < BYTES; k++) begin
      w_wdata[k*LANE_W +: LANE_W] = dat_i[8*k +: 8];
      w_rdata[8*k +: 8]           = w_q[k*LANE_W +: 8];
    end
  end

  assign w_perr = 1'b0;
`endif

  assign w_ack = r_ack && !w_perr;
  assign ack_o = w_ack;
  assign err_o = r_err || (r_ack && w_perr);
  assign dat_o = w_rdata;

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state <= IDLE;
      r_ac    <= '0;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (cyc_i && stb_i) begin
            if (!w_adr_ok) begin
              r_state <= ERR;
              r_err   <= 1'b1;
            end else begin
              r_ac    <= adr_i;
              r_ack   <= 1'b1;
              r_state <= (cti_i == CTI_INCR) ? BURST : ACK;
            end
          end
        end
        BURST: begin
          // Any beat that is not a continuing handshake ends the burst.
          if (w_burst_go) begin
            r_ac <= w_next;
            if (w_next_ok) begin
              r_ack   <= 1'b1;
              r_state <= BURST;
            end else begin
              r_err   <= 1'b1;
              r_state <= ERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  spram_be #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .LANE_W    (LANE_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .i_clk   (clk_i),
    .i_clr   (!rst_n_i),
    .i_we    (w_wr),
    .i_re    (w_rd),
    .i_be    (sel_i),
    .i_addr  (w_ram_addr),
    .i_wdata (w_wdata),
    .o_q     (w_q)
  );

endmodule

// File: tb/tb_wb_spram.sv
// Bench for wb_spram (DEPTH=200): vector table plus hand-written reset and
// parity sequences, checked cycle by cycle through an expectation queue.
module tb_wb_spram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 8;
  localparam int DEPTH  = 200;

  logic        clk = 1'b0;
  logic        rst_n_i;
  logic        cyc_i, stb_i, we_i;
  logic [7:0]  adr_i;
  logic [3:0]  sel_i;
  logic [31:0] dat_i;
  logic [2:0]  cti_i;
  logic [1:0]  bte_i;
  logic [31:0] dat_o;
  logic        ack_o, err_o;

  always #5 clk = ~clk;

  wb_spram #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .DEPTH     (DEPTH),
    .INIT_FILE ("")
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n_i),
    .cyc_i   (cyc_i),
    .stb_i   (stb_i),
    .we_i    (we_i),
    .adr_i   (adr_i),
    .sel_i   (sel_i),
    .dat_i   (dat_i),
    .cti_i   (cti_i),
    .bte_i   (bte_i),
    .dat_o   (dat_o),
    .ack_o   (ack_o),
    .err_o   (err_o)
  );

  typedef struct {
    logic        cyc, stb, we;
    logic [7:0]  adr;
    logic [3:0]  sel;
    logic [31:0] dat;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack, err, chk;
    logic [31:0] q;
    string       name;
  } vec_t;

  typedef struct {
    logic        ack, err, chk;
    logic [31:0] q;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[$];
  int   total = 0;
  int   bad   = 0;

  function automatic vec_t v(input logic cyc, stb, we, input logic [7:0] adr,
                             input logic [3:0] sel, input logic [31:0] dat,
                             input logic [2:0] cti, input logic [1:0] bte,
                             input logic ack, err, chk, input logic [31:0] q,
                             input string name);
    vec_t t;
    t.cyc = cyc; t.stb = stb; t.we = we; t.adr = adr; t.sel = sel; t.dat = dat;
    t.cti = cti; t.bte = bte; t.ack = ack; t.err = err; t.chk = chk; t.q = q;
    t.name = name;
    return t;
  endfunction

  task automatic check_out();
    exp_t e;
    if (sb.size() == 0) begin
      total++; bad++;
      $display("FAIL scoreboard_empty got=0 entries want>=1");
      return;
    end
    e = sb.pop_front();
    total++;
    if (ack_o !== e.ack) begin
      bad++;
      $display("FAIL %s.ack got=%0b want=%0b", e.name, ack_o, e.ack);
    end
    total++;
    if (err_o !== e.err) begin
      bad++;
      $display("FAIL %s.err got=%0b want=%0b", e.name, err_o, e.err);
    end
    if (e.chk) begin
      total++;
      if (dat_o !== e.q) begin
        bad++;
        $display("FAIL %s.dat got=%08h want=%08h", e.name, dat_o, e.q);
      end
    end
  endtask

  task automatic apply(input vec_t t);
    exp_t e;
    cyc_i = t.cyc; stb_i = t.stb; we_i = t.we; adr_i = t.adr;
    sel_i = t.sel; dat_i = t.dat; cti_i = t.cti; bte_i = t.bte;
    e.ack = t.ack; e.err = t.err; e.chk = t.chk; e.q = t.q; e.name = t.name;
    sb.push_back(e);
    @(posedge clk); #1;
    check_out();
  endtask

  task automatic idle(input logic ack, err, chk, input logic [31:0] q, input string name);
    apply(v(0, 0, 0, 8'h00, 4'h0, 32'h0, 3'b000, 2'b00, ack, err, chk, q, name));
  endtask

  task automatic classic_wr(input logic [7:0] adr, input logic [31:0] dat, input string name);
    apply(v(1, 1, 1, adr, 4'hF, dat, 3'b000, 2'b00, 1, 0, 0, 32'h0, name));
    apply(v(1, 1, 1, adr, 4'hF, dat, 3'b000, 2'b00, 0, 0, 0, 32'h0, name));
  endtask

  task automatic classic_rd(input logic [7:0] adr, input logic [31:0] q, input string name);
    apply(v(1, 1, 0, adr, 4'hF, 32'h0, 3'b000, 2'b00, 1, 0, 1, q, name));
    idle(0, 0, 1, q, name);
  endtask

  initial begin
    exp_t r;
    rst_n_i = 1'b0;
    cyc_i = 0; stb_i = 0; we_i = 0; adr_i = '0; sel_i = '0; dat_i = '0;
    cti_i = '0; bte_i = '0;

    // classic write, partial-lane write, classic read
    tbl.push_back(v(1,1,1,8'h10,4'hF,32'hDEADBEEF,3'b000,2'b00, 1,0,1,32'h0,"cw1_acc"));
    tbl.push_back(v(1,1,1,8'h10,4'hF,32'hDEADBEEF,3'b000,2'b00, 0,0,1,32'h0,"cw1_end"));
    tbl.push_back(v(1,1,1,8'h10,4'h2,32'h0000AA00,3'b000,2'b00, 1,0,0,32'h0,"cw2_acc"));
    tbl.push_back(v(1,1,1,8'h10,4'h2,32'h0000AA00,3'b000,2'b00, 0,0,1,32'h0,"cw2_end"));
    tbl.push_back(v(1,1,0,8'h10,4'hF,32'h0,3'b000,2'b00, 1,0,1,32'hDEADAAEF,"cr_acc"));
    tbl.push_back(v(1,1,0,8'h10,4'hF,32'h0,3'b000,2'b00, 0,0,1,32'hDEADAAEF,"cr_noreacc"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,1,32'hDEADAAEF,"cr_idle"));
    // linear burst write 0x20..0x23
    tbl.push_back(v(1,1,1,8'h20,4'hF,32'h1,3'b010,2'b00, 1,0,0,32'h0,"bw_acc"));
    tbl.push_back(v(1,1,1,8'h20,4'hF,32'h1,3'b010,2'b00, 1,0,0,32'h0,"bw_b1"));
    tbl.push_back(v(1,1,1,8'h20,4'hF,32'h2,3'b010,2'b00, 1,0,0,32'h0,"bw_b2"));
    tbl.push_back(v(1,1,1,8'h20,4'hF,32'h3,3'b010,2'b00, 1,0,0,32'h0,"bw_b3"));
    tbl.push_back(v(1,1,1,8'h20,4'hF,32'h4,3'b111,2'b00, 0,0,0,32'h0,"bw_b4"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,1,32'hDEADAAEF,"bw_idle"));
    // linear burst read 0x20..0x23
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b010,2'b00, 1,0,1,32'h1,"br_1"));
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b010,2'b00, 1,0,1,32'h2,"br_2"));
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b010,2'b00, 1,0,1,32'h3,"br_3"));
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b010,2'b00, 1,0,1,32'h4,"br_4"));
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b111,2'b00, 0,0,1,32'h4,"br_end"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,1,32'h4,"br_idle"));
    // wrap4 read from 0x22
    tbl.push_back(v(1,1,0,8'h22,4'hF,32'h0,3'b010,2'b01, 1,0,1,32'h3,"w4_1"));
    tbl.push_back(v(1,1,0,8'h22,4'hF,32'h0,3'b010,2'b01, 1,0,1,32'h4,"w4_2"));
    tbl.push_back(v(1,1,0,8'h22,4'hF,32'h0,3'b010,2'b01, 1,0,1,32'h1,"w4_3"));
    tbl.push_back(v(1,1,0,8'h22,4'hF,32'h0,3'b010,2'b01, 1,0,1,32'h2,"w4_4"));
    tbl.push_back(v(1,1,0,8'h22,4'hF,32'h0,3'b111,2'b01, 0,0,1,32'h2,"w4_end"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,0,32'h0,"w4_idle"));
    // out-of-range classic read and linear burst running off the end
    tbl.push_back(v(1,1,0,8'd200,4'hF,32'h0,3'b000,2'b00, 0,1,0,32'h0,"rng_rd"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,0,32'h0,"rng_rd_end"));
    tbl.push_back(v(1,1,0,8'd198,4'hF,32'h0,3'b010,2'b00, 1,0,0,32'h0,"rb_1"));
    tbl.push_back(v(1,1,0,8'd198,4'hF,32'h0,3'b010,2'b00, 1,0,0,32'h0,"rb_2"));
    tbl.push_back(v(1,1,0,8'd198,4'hF,32'h0,3'b010,2'b00, 0,1,0,32'h0,"rb_err"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,0,32'h0,"rb_end"));
    // burst abandoned by dropping cyc, then a fresh classic read
    tbl.push_back(v(1,1,0,8'h20,4'hF,32'h0,3'b010,2'b00, 1,0,1,32'h1,"ab_1"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,1,32'h1,"ab_cyc0"));
    tbl.push_back(v(1,1,0,8'h21,4'hF,32'h0,3'b000,2'b00, 1,0,1,32'h2,"ab_restart"));
    tbl.push_back(v(0,0,0,8'h00,4'h0,32'h0,3'b000,2'b00, 0,0,1,32'h2,"ab_idle"));

    repeat (2) @(posedge clk);
    #1;
    r.ack = 0; r.err = 0; r.chk = 1; r.q = 32'h0; r.name = "reset";
    sb.push_back(r);
    check_out();
    rst_n_i = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // reset in the middle of a write burst
    for (int a = 8'h30; a <= 8'h33; a++) classic_wr(8'(a), 32'h55555555, "rst_pre");
    classic_rd(8'h33, 32'h55555555, "rst_pre_rd");
    apply(v(1,1,1,8'h30,4'hF,32'hA1,3'b010,2'b00, 1,0,0,32'h0,"rst_acc"));
    apply(v(1,1,1,8'h30,4'hF,32'hA1,3'b010,2'b00, 1,0,0,32'h0,"rst_b1"));
    rst_n_i = 1'b0;
    apply(v(1,1,1,8'h30,4'hF,32'hA2,3'b010,2'b00, 0,0,1,32'h0,"rst_mid"));
    rst_n_i = 1'b1;
    idle(0, 0, 1, 32'h0, "rst_after");
    classic_rd(8'h30, 32'h000000A1, "rst_b1_kept");
    classic_rd(8'h31, 32'h55555555, "rst_b2_dropped");
    classic_rd(8'h32, 32'h55555555, "rst_b3_dropped");
    classic_rd(8'h33, 32'h55555555, "rst_b4_dropped");

`ifdef WB_SPRAM_PARITY_EN
    classic_wr(8'h05, 32'h12345678, "par_wr5");
    classic_wr(8'h06, 32'h0BADF00D, "par_wr6");
    dut.u_ram.r_mem[5][8] = ~dut.u_ram.r_mem[5][8];
    apply(v(1,1,0,8'h05,4'hF,32'h0,3'b000,2'b00, 0,1,1,32'h12345678,"par_bad5"));
    idle(0, 0, 0, 32'h0, "par_bad5_end");
    classic_rd(8'h06, 32'h0BADF00D, "par_ok6");
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
